dmem_ctrl: RTL



---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_bram.sv | 42 ++++
 rtl/dmem_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: funct3 access codes,
// FSM state encoding and the wait-state counter width.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_bram.sv
// DEPTH_WORDS x 32 word store: byte-enable synchronous write, asynchronous read.
// Word INIT_IDX reads as INIT_VAL from power-on. The storage array powers up
// to zero and the word at INIT_IDX is kept XOR-ed with INIT_VAL on both the
// write and read paths, so the preload needs no initial block and reset never
// disturbs it.
module dmem_bram #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          INIT_IDX    = 25,
  parameter logic [31:0] INIT_VAL    = 32'hDEADBEEF,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  localparam logic [AW-1:0] INIT_A = AW'(INIT_IDX);

  logic [31:0] mem [DEPTH_WORDS] = '{default: 32'h0};
  logic [31:0] wmask;
  logic [31:0] rmask;

  // Preload pattern applied to a given word index.
  assign wmask = (waddr == INIT_A) ? INIT_VAL : 32'h0;
  assign rmask = (raddr == INIT_A) ? INIT_VAL : 32'h0;

  // Byte-lane write; only enabled lanes change.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8] ^ wmask[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr] ^ rmask;

endmodule

// File: rtl/dmem_ctrl.sv
// RV32IM data-memory controller: request/response handshake with
// WAIT_STATES extra cycles, byte/half/word lane steering, load extension and
// fault reporting.
// Handshake: a request is accepted on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE; rsp_valid is a single-cycle pulse with no
// backpressure, and rsp_rdata/rsp_err are meaningful only while it is high.
// Optional macro DMEM_MISALIGN_ERR_EN: misaligned half/word accesses fault
// instead of being masked down to natural alignment.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 0,
  parameter int          INIT_IDX    = 25,
  parameter logic [31:0] INIT_VAL    = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [WCNT_W-1:0] WLOAD = (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;

  state_t            state, state_n;
  logic [WCNT_W-1:0] wcnt;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [31:0]       r_addr, r_wdata;

  logic              accept, enter_resp, mem_we;
  logic              cur_we;
  logic [2:0]        cur_f3;
  logic [31:0]       cur_addr, cur_wdata;
  logic [1:0]        lo;
  logic              f3_ok, oor, mis, err;
  logic [3:0]        be;
  logic [31:0]       wlane, mem_rdata, word_sh, ld_data;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;

  // With zero wait states RESP is entered on the accept edge itself, so decode
  // must see the live request in IDLE and the latched one afterwards.
  assign cur_we    = (state == S_IDLE) ? req_we     : r_we;
  assign cur_f3    = (state == S_IDLE) ? req_funct3 : r_f3;
  assign cur_addr  = (state == S_IDLE) ? req_addr   : r_addr;
  assign cur_wdata = (state == S_IDLE) ? req_wdata  : r_wdata;

  // Access decode: legality, range, alignment, lane enables and store steering.
  always_comb begin
    if (cur_we) f3_ok = (cur_f3 == F3_B) || (cur_f3 == F3_H) || (cur_f3 == F3_W);
    else        f3_ok = (cur_f3 == F3_B) || (cur_f3 == F3_H) || (cur_f3 == F3_W) ||
                        (cur_f3 == F3_BU) || (cur_f3 == F3_HU);
    oor = |cur_addr[31:AW+2];
`ifdef DMEM_MISALIGN_ERR_EN
    mis = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
          ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    lo  = cur_addr[1:0];
`else
    mis = 1'b0;
    case (cur_f3[1:0])
      2'b01:   lo = {cur_addr[1], 1'b0};
      2'b10:   lo = 2'b00;
      default: lo = cur_addr[1:0];
    endcase
`endif
    err = oor || !f3_ok || mis;
    be    = 4'b0000;
    wlane = cur_wdata;
    case (cur_f3[1:0])
      2'b00: begin be = 4'b0001 << lo;                     wlane = {4{cur_wdata[7:0]}};  end
      2'b01: begin be = lo[1] ? 4'b1100 : 4'b0011;         wlane = {2{cur_wdata[15:0]}}; end
      2'b10: begin be = 4'b1111;                           wlane = cur_wdata;            end
      default: begin be = 4'b0000;                         wlane = cur_wdata;            end
    endcase
  end

  // Load extraction and sign/zero extension of the selected lanes.
  always_comb begin
    word_sh = mem_rdata >> {lo, 3'b000};
    case (cur_f3)
      F3_B:    ld_data = {{24{word_sh[7]}}, word_sh[7:0]};
      F3_BU:   ld_data = {24'h0, word_sh[7:0]};
      F3_H:    ld_data = {{16{word_sh[15]}}, word_sh[15:0]};
      F3_HU:   ld_data = {16'h0, word_sh[15:0]};
      F3_W:    ld_data = mem_rdata;
      default: ld_data = 32'h0;
    endcase
  end

  // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (wcnt == '0) state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign enter_resp = (state_n == S_RESP);
  assign mem_we     = enter_resp && cur_we && !err && !rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Request latch, wait counter and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= '0;
      r_we      <= 1'b0;
      r_f3      <= 3'b000;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        wcnt    <= WLOAD;
      end else if (state == S_WAIT) begin
        wcnt <= wcnt - 1'b1;
      end
      if (enter_resp) begin
        rsp_rdata <= (cur_we || err) ? 32'h0 : ld_data;
        rsp_err   <= err;
      end
    end
  end

  dmem_bram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INIT_IDX   (INIT_IDX),
    .INIT_VAL   (INIT_VAL)
  ) u_bram (
    .clk  (clk),
    .we   (mem_we),
    .be   (be),
    .waddr(cur_addr[AW+1:2]),
    .wdata(wlane),
    .raddr(cur_addr[AW+1:2]),
    .rdata(mem_rdata)
  );

endmodule
